apb_stream_regif: RTL
=====================

APB_STREAM_REGIF -- requirements
Module: apb_stream_regif

Interface
Parameters:
REQ-001 SHALL have parameter DWIDTH, default 8, giving the data width of the TX/RX streams (1..16).
REQ-002 SHALL have parameter TX_FIFO_LOG2, default 3, giving log2 of the TX FIFO depth (1..7).
REQ-003 SHALL have parameter RX_FIFO_LOG2, default 3, giving log2 of the RX FIFO depth (1..7).

Ports:
REQ-004 SHALL have port clk, input, width 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, width 1: asynchronous, active-high reset.
REQ-006 SHALL have APB ports PSEL, PENABLE and PWRITE, each input, width 1.
REQ-007 SHALL have port PADDR, input, width 5.
REQ-008 SHALL have port PWDATA, input, width 32.
REQ-009 SHALL have port PRDATA, output, width 32; PREADY is not provided and there are no wait states.
REQ-010 SHALL have TX stream ports tx_data (output, DWIDTH), tx_has_data (output, 1) and tx_data_consume (input, 1).
REQ-011 SHALL have RX stream ports rx_data (input, DWIDTH), rx_has_space (output, 1) and rx_data_produce (input, 1).
REQ-012 SHALL have port rx_overflow, input, width 1: level signal from the backend.
REQ-013 SHALL have port IRQ, output, width 1.

Function
REQ-014 Access strobe acc = PSEL&&PENABLE; writes and pops take effect on the clk edge where acc is high.
REQ-015 0x00 DATA: read returns the RX head zero-extended and pops it if RX is non-empty; if RX is empty, returns 0 with no pop. Write pushes PWDATA[DWIDTH-1:0] to TX if TX is not full; otherwise the data is dropped and IRQ_STATUS b5 is set.
REQ-016 0x04 STATUS (RO): b0 RX non-empty; b1 TX non-full; b2 TX empty; [15:8] RX level; [23:16] TX level; other bits zero.
REQ-017 0x08 IRQ_STATUS: write is W1C on b[5:0]. Bits: b0 RX empty->non-empty; b1 TX full->non-full; b2 rx_overflow rising edge; b3 RX level rises to >= RX_THRESH; b4 RX timeout; b5 TX write dropped.
REQ-018 0x0C IRQ_ENABLE (RW) b[5:0]; IRQ = |(IRQ_STATUS & IRQ_ENABLE), combinational from registered state.
REQ-019 0x10 CTRL (RW): [7:0] RX_THRESH, 0 disables b3; [23:8] RX_TIMEOUT in cycles, 0 disables b4.
REQ-020 0x14 FLUSH (WO, self-clearing): writing b0=1 empties RX; writing b1=1 empties TX; takes effect in the same edge; levels read 0 next cycle.
REQ-021 Unmapped addresses read 0; writes to them are ignored.
REQ-022 All event detection (b0-b3) compares the current value against a value registered one cycle earlier.
REQ-023 Timeout counter: cleared on any RX push, pop or flush; increments while RX is non-empty; sets b4 once when it equals RX_TIMEOUT, then holds until the next clear.
REQ-024 If a hardware set and a W1C of the same bit occur in one cycle, the set wins.
REQ-025 Simultaneous APB push and tx_data_consume while TX is full: the push is dropped (b5 set) using the pre-edge full state.
REQ-026 Simultaneous RX push and APB pop: both complete; level is unchanged.
REQ-027 rx_data_produce while RX is full is ignored with no state change; tx_data_consume while TX is empty is ignored.
REQ-028 Levels range 0..2^LOG2 inclusive; the FIFO pointers wrap modulo depth.
REQ-029 FLUSH issued concurrently with a push: the flush wins and the pushed data is discarded.

Reset
REQ-030 On reset, both FIFOs are emptied and IRQ_STATUS, IRQ_ENABLE, CTRL, the timeout counter and the edge-history registers are cleared to 0.
REQ-031 Reset values: IRQ=0, tx_has_data=0, rx_has_space=1, PRDATA follows PADDR decode of the reset state.
REQ-032 Reset asserted mid-transfer aborts the transfer; no partial push or pop survives.

Structure
REQ-033 Register offsets, IRQ bit indices and CTRL field positions SHALL live in the shared package uart_regif_pkg.
REQ-034 A single sub-module, counted_fifo (DWIDTH, LOG2_SZ), SHALL provide push, pop, flush, full, empty and level, instantiated twice.

Verification
REQ-035 After reset, IRQ_ENABLE=0x01; push 1 RX byte 0x5A -> IRQ=1 next cycle, DATA read=0x5A, STATUS b0=0.
REQ-036 Write 9 bytes to DATA with depth 8 and no consume -> TX level=8, IRQ_STATUS=0x20; one consume -> b1 set.
REQ-037 CTRL RX_THRESH=4; push 3 then 1 -> b3 set on the 4th push only; W1C 0x08 on the same cycle as the 5th push -> b3 stays 0.
REQ-038 CTRL RX_TIMEOUT=10; push 1 byte, then idle -> b4 set exactly 10 cycles later, once; a pop clears the counter.
REQ-039 DWIDTH=12: write 0xABC -> tx_data=0xABC; FLUSH b1 -> TX level=0, tx_has_data=0.
REQ-040 Assert reset with RX holding 5 entries and IRQ set -> IRQ=0, level=0 asynchronously.

Source files
------------

// File: rtl/uart_regif_pkg.sv
// Shared register map, IRQ bit indices and CTRL layout for the APB stream register block.
package uart_regif_pkg;

  // Register offsets (byte addresses on the 5-bit PADDR bus)
  localparam logic [4:0] ADDR_DATA       = 5'h00;
  localparam logic [4:0] ADDR_STATUS     = 5'h04;
  localparam logic [4:0] ADDR_IRQ_STATUS = 5'h08;
  localparam logic [4:0] ADDR_IRQ_ENABLE = 5'h0C;
  localparam logic [4:0] ADDR_CTRL       = 5'h10;
  localparam logic [4:0] ADDR_FLUSH      = 5'h14;

  // IRQ_STATUS / IRQ_ENABLE bit indices
  localparam int unsigned IRQ_RX_NONEMPTY = 0;
  localparam int unsigned IRQ_TX_NONFULL  = 1;
  localparam int unsigned IRQ_RX_OVF      = 2;
  localparam int unsigned IRQ_RX_THRESH   = 3;
  localparam int unsigned IRQ_RX_TIMEOUT  = 4;
  localparam int unsigned IRQ_TX_DROP     = 5;
  localparam int unsigned NUM_IRQ         = 6;

  // FLUSH bit positions
  localparam int unsigned FLUSH_RX_BIT = 0;
  localparam int unsigned FLUSH_TX_BIT = 1;

  // CTRL layout: thresh in [7:0], timeout in [23:8]
  localparam int unsigned CTRL_THRESH_LSB  = 0;
  localparam int unsigned CTRL_TIMEOUT_LSB = 8;
  localparam int unsigned CTRL_WIDTH       = 24;

  typedef struct packed {
    logic [15:0] timeout;
    logic [7:0]  thresh;
  } ctrl_t;

endpackage

// File: rtl/counted_fifo.sv
// Synchronous FIFO with occupancy count; flush dominates push and pop.
module counted_fifo #(
  parameter int unsigned DWIDTH  = 8,
  parameter int unsigned LOG2_SZ = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [DWIDTH-1:0]  push_data,
  input  logic               pop,
  input  logic               flush,
  output logic [DWIDTH-1:0]  head,
  output logic               full,
  output logic               empty,
  output logic [LOG2_SZ:0]   level
);

  localparam int unsigned Depth = 2 ** LOG2_SZ;

  logic [DWIDTH-1:0]  mem_q [Depth];
  logic [LOG2_SZ-1:0] wptr_q, rptr_q;
  logic [LOG2_SZ:0]   level_q;
  logic               do_push, do_pop;

  assign full    = (level_q == {1'b1, {LOG2_SZ{1'b0}}});
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign head    = mem_q[rptr_q];
  // Full/empty are the pre-edge state, so a push into a full FIFO is lost even if a pop coincides
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Pointer and level bookkeeping; pointers wrap naturally at the depth
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + LOG2_SZ'(1);
      if (do_pop)  rptr_q <= rptr_q + LOG2_SZ'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + (LOG2_SZ + 1)'(1);
        2'b01:   level_q <= level_q - (LOG2_SZ + 1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage array; contents are don't-care while empty so no reset is needed
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= push_data;
  end

endmodule

// File: rtl/apb_stream_regif.sv
// APB register front-end bridging a TX and an RX byte stream through two counted FIFOs,
// with edge-detected interrupt sources and an RX idle timeout.
module apb_stream_regif
  import uart_regif_pkg::*;
#(
  parameter int unsigned DWIDTH       = 8,
  parameter int unsigned TX_FIFO_LOG2 = 3,
  parameter int unsigned RX_FIFO_LOG2 = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [4:0]        PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic [DWIDTH-1:0] tx_data,
  output logic              tx_has_data,
  input  logic              tx_data_consume,
  input  logic [DWIDTH-1:0] rx_data,
  output logic              rx_has_space,
  input  logic              rx_data_produce,
  input  logic              rx_overflow,
  output logic              IRQ
);

  logic                    acc, wr, rd;
  logic                    wr_data, rd_data, flush_rx, flush_tx;
  logic                    tx_full, tx_empty, rx_full, rx_empty;
  logic [TX_FIFO_LOG2:0]   tx_level;
  logic [RX_FIFO_LOG2:0]   rx_level;
  logic [7:0]              tx_level8, rx_level8;
  logic [DWIDTH-1:0]       rx_head;
  logic                    rx_above, rx_clr, tmo_inc, tmo_evt;
  logic [NUM_IRQ-1:0]      hw_set, w1c;
  logic [15:0]             tmo_cnt_d;
  logic                    unused_pwdata;

  ctrl_t                   ctrl_q;
  logic [NUM_IRQ-1:0]      irq_sts_q, irq_en_q;
  logic [15:0]             tmo_cnt_q;
  logic                    rx_empty_q, tx_full_q, ovf_q, rx_above_q;

  assign acc      = PSEL && PENABLE;
  assign wr       = acc && PWRITE;
  assign rd       = acc && !PWRITE;
  assign wr_data  = wr && (PADDR == ADDR_DATA);
  assign rd_data  = rd && (PADDR == ADDR_DATA);
  assign flush_rx = wr && (PADDR == ADDR_FLUSH) && PWDATA[FLUSH_RX_BIT];
  assign flush_tx = wr && (PADDR == ADDR_FLUSH) && PWDATA[FLUSH_TX_BIT];
  assign w1c      = (wr && (PADDR == ADDR_IRQ_STATUS)) ? PWDATA[NUM_IRQ-1:0] : '0;

  assign unused_pwdata = ^PWDATA[31:CTRL_WIDTH];

  counted_fifo #(
    .DWIDTH  (DWIDTH),
    .LOG2_SZ (TX_FIFO_LOG2)
  ) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_data),
    .push_data (PWDATA[DWIDTH-1:0]),
    .pop       (tx_data_consume),
    .flush     (flush_tx),
    .head      (tx_data),
    .full      (tx_full),
    .empty     (tx_empty),
    .level     (tx_level)
  );

  counted_fifo #(
    .DWIDTH  (DWIDTH),
    .LOG2_SZ (RX_FIFO_LOG2)
  ) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_data_produce),
    .push_data (rx_data),
    .pop       (rd_data),
    .flush     (flush_rx),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .level     (rx_level)
  );

  assign tx_has_data  = !tx_empty;
  assign rx_has_space = !rx_full;
  assign tx_level8    = 8'(tx_level);
  assign rx_level8    = 8'(rx_level);
  assign rx_above     = (ctrl_q.thresh != 8'd0) && (rx_level8 >= ctrl_q.thresh);

  // Timeout counter: any RX activity restarts it; it parks at the limit so b4 fires once
  always_comb begin
    rx_clr    = (rx_data_produce && !rx_full) || (rd_data && !rx_empty) || flush_rx;
    tmo_inc   = !rx_clr && !rx_empty && (tmo_cnt_q < ctrl_q.timeout);
    tmo_evt   = tmo_inc && ((tmo_cnt_q + 16'd1) == ctrl_q.timeout);
    tmo_cnt_d = tmo_cnt_q;
    if (rx_clr)       tmo_cnt_d = '0;
    else if (tmo_inc) tmo_cnt_d = tmo_cnt_q + 16'd1;
  end

  // Hardware interrupt sources, each an edge against last cycle's history
  always_comb begin
    hw_set                  = '0;
    hw_set[IRQ_RX_NONEMPTY] = !rx_empty && rx_empty_q;
    hw_set[IRQ_TX_NONFULL]  = !tx_full && tx_full_q;
    hw_set[IRQ_RX_OVF]      = rx_overflow && !ovf_q;
    hw_set[IRQ_RX_THRESH]   = rx_above && !rx_above_q;
    hw_set[IRQ_RX_TIMEOUT]  = tmo_evt;
    hw_set[IRQ_TX_DROP]     = wr_data && tx_full;
  end

  // Control/status registers and edge history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q     <= '0;
      irq_sts_q  <= '0;
      irq_en_q   <= '0;
      tmo_cnt_q  <= '0;
      rx_empty_q <= 1'b0;
      tx_full_q  <= 1'b0;
      ovf_q      <= 1'b0;
      rx_above_q <= 1'b0;
    end else begin
      // Hardware set is ORed after the clear so it wins a same-cycle W1C
      irq_sts_q <= (irq_sts_q & ~w1c) | hw_set;
      if (wr && (PADDR == ADDR_IRQ_ENABLE)) irq_en_q <= PWDATA[NUM_IRQ-1:0];
      if (wr && (PADDR == ADDR_CTRL))       ctrl_q   <= ctrl_t'(PWDATA[CTRL_WIDTH-1:0]);
      tmo_cnt_q  <= tmo_cnt_d;
      rx_empty_q <= rx_empty;
      tx_full_q  <= tx_full;
      ovf_q      <= rx_overflow;
      rx_above_q <= rx_above;
    end
  end

  assign IRQ = |(irq_sts_q & irq_en_q);

  // Read data mux, purely from PADDR and registered state
  always_comb begin
    PRDATA = '0;
    case (PADDR)
      ADDR_DATA: begin
        if (!rx_empty) PRDATA[DWIDTH-1:0] = rx_head;
      end
      ADDR_STATUS: begin
        PRDATA[0]     = !rx_empty;
        PRDATA[1]     = !tx_full;
        PRDATA[2]     = tx_empty;
        PRDATA[15:8]  = rx_level8;
        PRDATA[23:16] = tx_level8;
      end
      ADDR_IRQ_STATUS: PRDATA[NUM_IRQ-1:0] = irq_sts_q;
      ADDR_IRQ_ENABLE: PRDATA[NUM_IRQ-1:0] = irq_en_q;
      ADDR_CTRL:       PRDATA[CTRL_WIDTH-1:0] = ctrl_q;
      default:         PRDATA = '0;
    endcase
  end

endmodule
